// File: rtl/buf_pool_pkg.sv
// buf_pool_pkg: shared buffer-pool types and the lowest-free-index helper.
package buf_pool_pkg;
    localparam int NBUF = 16;
    localparam int ADDR_W = 4;
    typedef logic [ADDR_W-1:0] buf_addr_t;
    typedef logic [NBUF-1:0] busy_vec_t;
    function automatic buf_addr_t first_free(input busy_vec_t busy);
        first_free = '0;
        for (int i = NBUF - 1; i >= 0; i--)
            if (!busy[i]) first_free = buf_addr_t'(i);
    endfunction
endpackage

// File: rtl/buf_pool_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, scanning upward from i_ptr with wrap.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    input  logic                 i_enable,
    output logic [N-1:0]         o_gnt
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] w_idx;
    // Walk offsets high to low so the closest requester to i_ptr wins last.
    always_comb begin
        o_gnt = '0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (i_enable && i_req[w_idx]) o_gnt = N'(1) << w_idx;
        end
    end
endmodule

// File: rtl/buf_pool_arbiter.sv
// buf_pool_arbiter: 16-entry buffer pool shared by NREQ requesters; BUF_QUOTA_EN adds per-requester limits.
module buf_pool_arbiter
    import buf_pool_pkg::*;
#(
    parameter int NREQ = 4
`ifdef BUF_QUOTA_EN
    , parameter int MAX_PER_REQ = 6
`endif
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [NREQ-1:0]         i_req,
    output logic [NREQ-1:0]         o_gnt,
    output logic [3:0]              o_gnt_addr,
    input  logic                    i_free_valid,
    input  logic [$clog2(NREQ)-1:0] i_free_id,
    input  logic [3:0]              i_free_addr,
    output logic [4:0]              o_count,
    output logic                    o_full,
    output logic                    o_free_err
);
    localparam int IDW = $clog2(NREQ);
    busy_vec_t      r_busy;
    logic [IDW-1:0] r_owner [NBUF];
    logic [4:0]     r_count;
    logic [IDW-1:0] r_rr_ptr;
    logic           r_free_err;
    logic [IDW-1:0] w_gnt_id;
    logic [NREQ-1:0] w_mask, w_gnt;
    logic           w_full, w_gnt_any, w_free_ok;
    buf_addr_t      w_addr;
    assign w_full = r_count == 5'(NBUF);
    assign w_addr = first_free(r_busy);
    assign w_gnt_any = |w_gnt;
    assign w_free_ok = i_free_valid && r_busy[i_free_addr] && r_owner[i_free_addr] == i_free_id;
    always_comb begin
        w_gnt_id = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_gnt[i]) w_gnt_id = IDW'(i);
    end
    rr_arbiter #(.N(NREQ)) u_rr (
        .i_req(i_req & ~w_mask),
        .i_ptr(r_rr_ptr),
        .i_enable(!w_full),
        .o_gnt(w_gnt)
    );
    assign o_gnt = w_gnt;
    assign o_gnt_addr = w_gnt_any ? w_addr : '0;
    assign o_count = r_count;
    assign o_full = w_full;
    assign o_free_err = r_free_err;
    // Grant and free never touch the same entry: the grant picks a non-busy one.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_busy <= '0;
            for (int i = 0; i < NBUF; i++) r_owner[i] <= '0;
            r_count <= '0;
            r_rr_ptr <= '0;
            r_free_err <= 1'b0;
        end else begin
            if (w_gnt_any) begin
                r_busy[w_addr] <= 1'b1;
                r_owner[w_addr] <= w_gnt_id;
                r_rr_ptr <= w_gnt_id == IDW'(NREQ - 1) ? '0 : w_gnt_id + 1'b1;
            end
            if (w_free_ok) r_busy[i_free_addr] <= 1'b0;
            r_count <= r_count + 5'(w_gnt_any) - 5'(w_free_ok);
            r_free_err <= i_free_valid && !w_free_ok;
        end
    end
`ifdef BUF_QUOTA_EN
    logic [2:0] r_out [NREQ];
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < NREQ; i++)
            r_out[i] <= i_reset ? 3'd0 : r_out[i] + 3'(w_gnt[i]) - 3'(w_free_ok && i_free_id == IDW'(i));
    end
    always_comb begin
        for (int i = 0; i < NREQ; i++) w_mask[i] = r_out[i] == 3'(MAX_PER_REQ);
    end
`else
    assign w_mask = '0;
`endif
endmodule

// File: tb/tb_buf_pool_arbiter.sv
// tb_buf_pool_arbiter: scoreboard bench against an array-based pool model.
module tb_buf_pool_arbiter;
    localparam int NREQ = 4;
    localparam int IDW = 2;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic            i_reset = 1'b1;
    logic [NREQ-1:0] i_req = '0;
    logic            i_free_valid = 1'b0;
    logic [IDW-1:0]  i_free_id = '0;
    logic [3:0]      i_free_addr = '0;
    logic [NREQ-1:0] o_gnt;
    logic [3:0]      o_gnt_addr;
    logic [4:0]      o_count;
    logic            o_full, o_free_err;
    buf_pool_arbiter #(.NREQ(NREQ)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_req(i_req), .o_gnt(o_gnt),
        .o_gnt_addr(o_gnt_addr), .i_free_valid(i_free_valid), .i_free_id(i_free_id),
        .i_free_addr(i_free_addr), .o_count(o_count), .o_full(o_full), .o_free_err(o_free_err)
    );
    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [3:0]      addr;
        logic [4:0]      count;
        logic            full;
        logic            ferr;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;
    bit m_busy [16];
    int m_owner [16];
    int m_out [NREQ];
    int m_ptr;
    bit m_ferr;
    function automatic int m_count();
        int c = 0;
        for (int b = 0; b < 16; b++) c += int'(m_busy[b]);
        return c;
    endfunction
    function automatic bit quota_ok(input int id);
`ifdef BUF_QUOTA_EN
        return m_out[id] < 6;
`else
        return 1'b1;
`endif
    endfunction
    task automatic model_reset();
        for (int b = 0; b < 16; b++) begin
            m_busy[b] = 0;
            m_owner[b] = 0;
        end
        for (int i = 0; i < NREQ; i++) m_out[i] = 0;
        m_ptr = 0;
        m_ferr = 0;
    endtask
    // One cycle: drive inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input bit rst, input logic [NREQ-1:0] req, input bit fv, input int fid, input int fa);
        exp_t e;
        int gid, addr, cnt, id;
        bit ok;
        @(posedge clk);
        #1;
        i_reset = rst;
        i_req = req;
        i_free_valid = fv;
        i_free_id = IDW'(fid);
        i_free_addr = 4'(fa);
        if (rst) begin
            model_reset();
            return;
        end
        cnt = m_count();
        gid = -1;
        addr = 0;
        if (cnt < 16)
            for (int k = 0; k < NREQ; k++) begin
                id = (m_ptr + k) % NREQ;
                if (gid < 0 && req[id] && quota_ok(id)) gid = id;
            end
        if (gid >= 0)
            for (int b = 15; b >= 0; b--) if (!m_busy[b]) addr = b;
        e.gnt = gid >= 0 ? NREQ'(1) << gid : '0;
        e.addr = 4'(addr);
        e.count = 5'(cnt);
        e.full = cnt == 16;
        e.ferr = m_ferr;
        q.push_back(e);
        ok = fv && m_busy[fa] && m_owner[fa] == fid;
        if (gid >= 0) begin
            m_busy[addr] = 1;
            m_owner[addr] = gid;
            m_ptr = (gid + 1) % NREQ;
            m_out[gid]++;
        end
        if (ok) begin
            m_busy[fa] = 0;
            m_out[fid]--;
        end
        m_ferr = fv && !ok;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("gnt", 32'(o_gnt), 32'(e.gnt));
            chk("gnt_addr", 32'(o_gnt_addr), 32'(e.addr));
            chk("count", 32'(o_count), 32'(e.count));
            chk("full", 32'(o_full), 32'(e.full));
            chk("free_err", 32'(o_free_err), 32'(e.ferr));
        end
    end
    initial begin
        int fv, fa, fid, pct;
        logic [NREQ-1:0] req;
        model_reset();
        repeat (2) step(1, '0, 0, 0, 0);
        repeat (2) step(0, '0, 0, 0, 0);
        repeat (4) step(0, 4'hF, 0, 0, 0);
        repeat (12) step(0, 4'h1, 0, 0, 0);
        repeat (2) step(0, 4'h4, 0, 0, 0);
        step(0, 4'h4, 1, 0, 5);
        step(0, 4'h4, 0, 0, 0);
        step(0, 4'h0, 0, 0, 0);
        step(0, 4'h0, 1, 1, 0);
        step(0, 4'h0, 0, 0, 0);
        step(0, 4'h0, 1, 0, 9);
        step(0, 4'h0, 1, 0, 9);
        repeat (2) step(0, 4'h0, 0, 0, 0);
        step(1, '0, 0, 0, 0);
        repeat (3) step(0, 4'h1, 0, 0, 0);
        step(0, 4'h2, 1, 0, 0);
        repeat (2) step(0, 4'h0, 0, 0, 0);
`ifdef BUF_QUOTA_EN
        step(1, '0, 0, 0, 0);
        repeat (8) step(0, 4'h1, 0, 0, 0);
        step(0, 4'h1, 1, 0, 2);
        repeat (2) step(0, 4'h1, 0, 0, 0);
`endif
        for (int c = 0; c < 1500; c++) begin
            pct = (c / 100) % 3 == 0 ? 15 : (c / 100) % 3 == 1 ? 50 : 85;
            req = (c / 100) % 3 == 2 && $urandom_range(0, 3) != 0 ? '0 : NREQ'($urandom_range(0, 15));
            fv = int'($urandom_range(0, 99) < pct);
            fa = $urandom_range(0, 15);
            fid = $urandom_range(0, NREQ - 1);
            if (m_busy[fa] && $urandom_range(0, 3) != 0) fid = m_owner[fa];
            step(c == 700, req, fv != 0, fid, fa);
        end
        step(0, '0, 0, 0, 0);
        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
